// File: rtl/uart_line_buffer_if.sv
// Byte handshake bundle for the UART line buffer.
// The slave side is the buffer; the master side feeds rx and sinks tx.
interface uart_line_buffer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       rx_drop;

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid,
        output busy,
        output rx_drop
    );

    modport master (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid,
        input  busy,
        input  rx_drop
    );
endinterface

// File: rtl/uart_line_buffer.sv
// Collects rx bytes into a line, then replays the line plus CR LF on tx.
// Bytes arriving while full or replaying are dropped and flagged.
module uart_line_buffer #(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_line_buffer_if.slave   bus
);

    typedef enum logic [2:0] {
        COLLECT,
        FETCH,
        SEND,
        CR,
        LF
    } state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t      state_q, state_d;
    logic [AW:0] count_q, count_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        drop_q, drop_d;
    logic        mem_we;
    logic        rd_load;
    logic        is_term;
    logic        busy;

    logic [7:0]  mem [DEPTH];

    assign is_term = (bus.rx_data == 8'h0D) ||
                     (bus.rx_data == 8'h0A);
    assign busy    = (state_q != COLLECT);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        mem_we     = 1'b0;
        rd_load    = 1'b0;
        // every strobe outside COLLECT is lost, terminators included
        drop_d     = bus.rx_valid && busy;

        unique case (state_q)
            COLLECT: begin
                if (bus.rx_valid && !is_term) begin
                    if (count_q == FULL) begin
                        drop_d = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        count_d = count_q + 1'b1;
                    end
                end else if (bus.rx_valid && count_q != '0) begin
                    rd_ptr_d = '0;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                rd_load    = 1'b1;
                tx_valid_d = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                if (bus.tx_ready) begin
                    if (rd_ptr_q == count_q - 1'b1) begin
                        tx_data_d = 8'h0D;
                        state_d   = CR;
                    end else begin
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        tx_valid_d = 1'b0;
                        state_d    = FETCH;
                    end
                end
            end
            CR: begin
                if (bus.tx_ready) begin
                    tx_data_d = 8'h0A;
                    state_d   = LF;
                end
            end
            LF: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                    count_d    = '0;
                    state_d    = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[count_q[AW-1:0]] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_valid_q <= tx_valid_d;
            drop_q     <= drop_d;
            if (rd_load) begin
                tx_data_q <= mem[rd_ptr_q[AW-1:0]];
            end else begin
                tx_data_q <= tx_data_d;
            end
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = busy;
    assign bus.rx_drop  = drop_q;

endmodule

// File: tb/tb_uart_line_buffer.sv
// Bench for uart_line_buffer: directed scenarios plus random traffic
// checked against a queue-based line model.
module tb_uart_line_buffer;

    localparam int DEPTH = 8;

    logic clk;
    logic rst_n;

    uart_line_buffer_if bus();

    uart_line_buffer #(.DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] line_q[$];
    bit         m_busy;
    bit         m_gap;
    bit         m_drop;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        line_q.delete();
        m_busy = 1'b0;
        m_gap  = 1'b0;
        m_drop = 1'b0;
    endtask

    // One clock cycle: check what the DUT shows now, then apply inputs
    // and advance the line model to what it must show next cycle.
    task automatic cyc(input bit rv, input logic [7:0] rd, input bit tr);
        bit         exp_valid;
        bit         hs;
        bit         busy_n;
        bit         gap_n;
        logic [8:0] want;
        @(negedge clk);
        exp_valid = m_busy && !m_gap;
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("tx_valid", 32'(bus.tx_valid), 32'(exp_valid));
        if (bus.tx_valid) begin
            want = (exp_q.size() > 0) ? {1'b0, exp_q[0]} : 9'h100;
            check("tx_data", 32'(bus.tx_data), 32'(want));
        end
        check("rx_drop", 32'(bus.rx_drop), 32'(m_drop));

        bus.rx_valid = rv;
        bus.rx_data  = rd;
        bus.tx_ready = tr;

        hs     = exp_valid && tr;
        busy_n = m_busy;
        gap_n  = 1'b0;
        m_drop = 1'b0;
        if (rv) begin
            if (m_busy) begin
                m_drop = 1'b1;
            end else if (rd == 8'h0D || rd == 8'h0A) begin
                if (line_q.size() > 0) begin
                    foreach (line_q[i]) exp_q.push_back(line_q[i]);
                    exp_q.push_back(8'h0D);
                    exp_q.push_back(8'h0A);
                    line_q.delete();
                    busy_n = 1'b1;
                    gap_n  = 1'b1;
                end
            end else if (line_q.size() < DEPTH) begin
                line_q.push_back(rd);
            end else begin
                m_drop = 1'b1;
            end
        end
        if (hs && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) busy_n = 1'b0;
            else if (exp_q.size() > 2) gap_n = 1'b1;
        end
        m_busy = busy_n;
        m_gap  = gap_n;
    endtask

    task automatic do_reset();
        #1;
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        #1;
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_rx_drop", 32'(bus.rx_drop), 32'd0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_line(input logic [7:0] b[$], input bit tr);
        foreach (b[i]) cyc(1'b1, b[i], tr);
    endtask

    task automatic idle(input int n, input bit tr);
        repeat (n) cyc(1'b0, 8'h00, tr);
    endtask

    int k;
    int stall;
    bit rv;
    bit tr;
    logic [7:0] rd;

    initial begin
        rst_n        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        model_clear();
        do_reset();
        idle(2, 1'b1);

        // basic line, terminator-to-idle latency
        send_line('{8'h01, 8'h02, 8'h03, 8'h04, 8'h0D}, 1'b1);
        for (k = 1; k <= 40; k++) begin
            cyc(1'b0, 8'h00, 1'b1);
            if (!bus.busy) break;
        end
        check("busy_len", 32'(k), 32'd11);
        idle(2, 1'b1);

        // CR LF pair: trailing 0A ignored once idle
        send_line('{8'h41, 8'h0D}, 1'b1);
        idle(8, 1'b1);
        send_line('{8'h0A}, 1'b1);
        idle(4, 1'b1);

        // overflow: DEPTH+1 data bytes
        for (int i = 0; i <= DEPTH; i++) cyc(1'b1, 8'(8'h10 + i), 1'b1);
        send_line('{8'h0D}, 1'b1);
        idle(2*DEPTH + 6, 1'b1);

        // backpressure on the second byte
        send_line('{8'h01, 8'h02, 8'h0D}, 1'b0);
        idle(1, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);
        idle(10, 1'b0);
        idle(8, 1'b1);

        // byte during replay is dropped
        send_line('{8'h01, 8'h0D}, 1'b1);
        idle(1, 1'b1);
        send_line('{8'h55}, 1'b1);
        idle(6, 1'b1);
        send_line('{8'h66, 8'h0D}, 1'b1);
        idle(8, 1'b1);

        // reset in the middle of SEND
        send_line('{8'h09, 8'h0A}, 1'b0);
        idle(3, 1'b0);
        check("pre_rst_valid", 32'(bus.tx_valid), 32'd1);
        do_reset();
        send_line('{8'h07, 8'h0D}, 1'b1);
        idle(8, 1'b1);

        // random traffic
        stall = 0;
        for (int c = 0; c < 4000; c++) begin
            rv = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0)
                rd = $urandom_range(0, 1) ? 8'h0D : 8'h0A;
            else
                rd = 8'($urandom_range(0, 255));
            if (stall > 0) begin
                stall--;
                tr = 1'b0;
            end else begin
                if ($urandom_range(0, 49) == 0) stall = $urandom_range(3, 15);
                tr = ($urandom_range(0, 3) != 0);
            end
            cyc(rv, rd, tr);
        end
        idle(3*DEPTH + 10, 1'b1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
